// File: rtl/ptr_sync_pkg.sv
// Shared constants and helpers for the multi-channel gray-pointer synchroniser.
package ptr_sync_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int NUM_CH_MAX      = 8;

  // Warm-up counter must hold the value SYNC_STAGES+1.
  function automatic int cnt_w(input int stages);
    return $clog2(stages + 2);
  endfunction

  // Gray to binary for the low w bits of g; bits at and above w must be zero.
  function automatic logic [31:0] g2b(input logic [31:0] g, input int w);
    logic [31:0] b;
    b = g;
    for (int i = 30; i >= 0; i--)
      if (i < w - 1) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/ptr_sync_chain.sv
// One W-bit, STAGES-deep synchroniser flop chain with asynchronous active-low reset.
module ptr_sync_chain #(
  parameter int W      = 5,
  parameter int STAGES = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [STAGES-1:0][W-1:0] stage_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stage_q <= '0;
    else         stage_q <= {stage_q[STAGES-2:0], d_i};
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/ptr_sync_multi.sv
// Multi-channel gray-pointer synchroniser into wclk with warm-up tracking.
// Define PTR_SYNC_BIN_EN to build the binary, delta and advance outputs.
module ptr_sync_multi
  import ptr_sync_pkg::*;
#(
  parameter int ADDRSIZE    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int NUM_CH      = 1
) (
  input  logic                           wclk,
  input  logic                           wrst_n,
  input  logic [NUM_CH*(ADDRSIZE+1)-1:0] rptr,
  output logic [NUM_CH*(ADDRSIZE+1)-1:0] wq_rptr,
  output logic [NUM_CH*(ADDRSIZE+1)-1:0] wq_rbin,
  output logic [NUM_CH*(ADDRSIZE+1)-1:0] wq_rdelta,
  output logic [NUM_CH-1:0]              wq_radv,
  output logic                           sync_valid
);

  localparam int PW = ADDRSIZE + 1;
  localparam int CW = cnt_w(SYNC_STAGES);
  localparam logic [CW-1:0] CNT_MAX = CW'(SYNC_STAGES + 1);

  logic [NUM_CH-1:0][PW-1:0] rptr_ch, gray_s;
  logic [CW-1:0]             cnt_q, cnt_d;

  assign rptr_ch = rptr;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ptr_sync_chain #(.W(PW), .STAGES(SYNC_STAGES)) u_chain (
      .clk_i  (wclk),
      .rst_ni (wrst_n),
      .d_i    (rptr_ch[c]),
      .q_o    (gray_s[c])
    );
  end

  assign wq_rptr = gray_s;

  // Saturating warm-up count: valid once the chain has flushed its reset zeros.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign sync_valid = (cnt_q == CNT_MAX);

`ifdef PTR_SYNC_BIN_EN
  logic [NUM_CH-1:0][PW-1:0] rbin_q, rbin_d, rdelta_q, rdelta_d;
  logic [NUM_CH-1:0]         radv_q, radv_d;

  // rbin tracks during warm-up so the first valid delta is against a real baseline.
  always_comb begin
    rbin_d   = '0;
    rdelta_d = '0;
    radv_d   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      rbin_d[c] = PW'(g2b(32'(gray_s[c]), PW));
      if (sync_valid) rdelta_d[c] = rbin_d[c] - rbin_q[c];
      radv_d[c] = |rdelta_d[c];
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      rbin_q   <= '0;
      rdelta_q <= '0;
      radv_q   <= '0;
    end else begin
      rbin_q   <= rbin_d;
      rdelta_q <= rdelta_d;
      radv_q   <= radv_d;
    end
  end

  assign wq_rbin   = rbin_q;
  assign wq_rdelta = rdelta_q;
  assign wq_radv   = radv_q;
`else
  assign wq_rbin   = '0;
  assign wq_rdelta = '0;
  assign wq_radv   = '0;
`endif

endmodule

// File: tb/tb_ptr_sync_multi.sv
// Randomised bench for ptr_sync_multi against an edge-history reference model.
module tb_ptr_sync_multi;

  localparam int ADDRSIZE = 4;
  localparam int PW       = ADDRSIZE + 1;
  localparam int S        = 3;
  localparam int NCH      = 3;
`ifdef PTR_SYNC_BIN_EN
  localparam bit BIN_EN = 1'b1;
`else
  localparam bit BIN_EN = 1'b0;
`endif

  typedef logic [NCH-1:0][PW-1:0] vec_t;

  logic           wclk = 1'b0;
  logic           wrst_n;
  logic [NCH*PW-1:0] rptr, wq_rptr, wq_rbin, wq_rdelta;
  logic [NCH-1:0] wq_radv;
  logic           sync_valid;

  int   checks = 0;
  int   errors = 0;
  int   n      = 0;
  vec_t hist [0:1023];
  vec_t cur;

  always #5 wclk = ~wclk;

  ptr_sync_multi #(.ADDRSIZE(ADDRSIZE), .SYNC_STAGES(S), .NUM_CH(NCH)) dut (
    .wclk       (wclk),
    .wrst_n     (wrst_n),
    .rptr       (rptr),
    .wq_rptr    (wq_rptr),
    .wq_rbin    (wq_rbin),
    .wq_rdelta  (wq_rdelta),
    .wq_radv    (wq_radv),
    .sync_valid (sync_valid)
  );

  function automatic logic [PW-1:0] b2g(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic drive(input vec_t b);
    cur = b;
    for (int c = 0; c < NCH; c++) rptr[c*PW +: PW] = b2g(b[c]);
  endtask

  // Expected outputs after edge n from the history of sampled binary pointers.
  task automatic check_model();
    vec_t og, ob, od;
    logic [PW-1:0] eg, eb, ed;
    og = wq_rptr; ob = wq_rbin; od = wq_rdelta;
    for (int c = 0; c < NCH; c++) begin
      eg = (n >= S)     ? b2g(hist[n-S+1][c]) : '0;
      eb = (n >= S + 1) ? hist[n-S][c] : '0;
      ed = (n >= S + 2) ? PW'(hist[n-S][c] - hist[n-S-1][c]) : '0;
      if (!BIN_EN) begin
        eb = '0;
        ed = '0;
      end
      chk($sformatf("gray%0d", c),  32'(og[c]),       32'(eg));
      chk($sformatf("bin%0d", c),   32'(ob[c]),       32'(eb));
      chk($sformatf("delta%0d", c), 32'(od[c]),       32'(ed));
      chk($sformatf("adv%0d", c),   32'(wq_radv[c]),  32'(ed != '0));
    end
    chk("sync_valid", 32'(sync_valid), 32'(n >= S + 1));
  endtask

  task automatic cycle(input vec_t b);
    drive(b);
    @(posedge wclk);
    n++;
    hist[n] = cur;
    @(negedge wclk);
    check_model();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rptr"},  32'(wq_rptr),    0);
    chk({tag, "_rbin"},  32'(wq_rbin),    0);
    chk({tag, "_delta"}, 32'(wq_rdelta),  0);
    chk({tag, "_adv"},   32'(wq_radv),    0);
    chk({tag, "_valid"}, 32'(sync_valid), 0);
  endtask

  task automatic do_reset(input vec_t preset);
    @(negedge wclk);
    wrst_n = 1'b0;
    drive(preset);
    repeat (3) @(negedge wclk);
    check_zero("rst");
    wrst_n = 1'b1;
    n = 0;
  endtask

  initial begin
    vec_t v;
    wrst_n = 1'b0;
    v = '0;
    drive(v);
    #1 check_zero("por");
    do_reset(v);
    repeat (8) cycle(v);

    // Preset before release: baseline captured, no spurious delta.
    for (int c = 0; c < NCH; c++) v[c] = PW'(9);
    do_reset(v);
    repeat (10) cycle(v);

    // Single steps, one per 4 cycles on channel 0.
    for (int s = 0; s < 4; s++) begin
      v[0] = PW'(s);
      repeat (4) cycle(v);
    end

    // Wrap 30 -> 31 -> 0 -> 1 on consecutive cycles.
    v[0] = PW'(30);
    repeat (5) cycle(v);
    for (int s = 31; s < 34; s++) begin
      v[0] = PW'(s);
      cycle(v);
    end
    repeat (5) cycle(v);

    // Channel 1 jumps by 5 in one sample window.
    v[1] = PW'(7);
    repeat (5) cycle(v);
    v[1] = PW'(12);
    repeat (6) cycle(v);

    // Random advances: hold, +1, random jump, or arbitrary value.
    for (int k = 0; k < 300; k++) begin
      for (int c = 0; c < NCH; c++) begin
        case ($urandom_range(0, 3))
          0: ;
          1: v[c] = v[c] + PW'(1);
          2: v[c] = v[c] + PW'($urandom_range(0, 31));
          default: v[c] = PW'($urandom);
        endcase
      end
      cycle(v);
    end

    // Asynchronous reset mid-cycle with non-zero pointers.
    for (int c = 0; c < NCH; c++) v[c] = PW'(c + 20);
    repeat (6) cycle(v);
    @(posedge wclk);
    #2 wrst_n = 1'b0;
    #1 check_zero("async");
    repeat (2) @(negedge wclk);
    check_zero("hold");
    wrst_n = 1'b1;
    n = 0;
    repeat (8) cycle(v);
    v[2] = v[2] + PW'(3);
    repeat (6) cycle(v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
